// File: rtl/nios_pio_pkg.sv
// Shared register map and edge-type encodings for the Nios II PIO slaves.
// Pure constants; no logic, no latency, no flow control.
package nios_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_debounce.sv
// One input bit: 2-flop synchroniser, then a stable register that follows sync2 directly or,
// with NIOS_PIO_DEBOUNCE_EN, only after DEBOUNCE_CYCLES consecutive differing samples; no backpressure.
module nios_pio_debounce
  import nios_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  logic sync1;
  logic sync2;

`ifdef NIOS_PIO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // Counter only runs while sync2 disagrees with stable, so it tops out at DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= IDLE_LEVEL;
      sync2  <= IDLE_LEVEL;
      stable <= IDLE_LEVEL;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= IDLE_LEVEL;
      sync2  <= IDLE_LEVEL;
      stable <= IDLE_LEVEL;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      stable <= sync2;
    end
  end
`endif

endmodule

// File: rtl/nios_system_push_buttons.sv
// Avalon-MM input PIO: synchronised/debounced buttons, per-bit edge capture, maskable level irq.
// Read latency 1 cycle, no wait states; NIOS_PIO_DEBOUNCE_EN enables the per-bit debounce counters.
module nios_system_push_buttons
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_FALL,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .stable (stable[i])
    );
  end

  if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign edges = stable_d & ~stable;
  end else if (EDGE_TYPE == EDGE_RISE) begin : g_rise
    assign edges = ~stable_d & stable;
  end else begin : g_any
    assign edges = stable_d ^ stable;
  end

  assign wr_en   = chipselect && !write_n;
  assign cap_clr = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
      default:          rd_mux = '0;
    endcase
  end

  // A new edge is OR-ed in after the clear, so set beats clear on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d    <= {WIDTH{IDLE_LEVEL}};
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      stable_d    <= stable;
      edgecapture <= (edgecapture & ~cap_clr) | edges;
      if (wr_en && address == PIO_ADDR_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      readdata <= rd_mux;
      irq      <= |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_nios_system_push_buttons.sv
// Directed bench for the push-button PIO; timing expectations follow NIOS_PIO_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_nios_system_push_buttons;
  import nios_pio_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;
`ifdef NIOS_PIO_DEBOUNCE_EN
  localparam int LAT  = 2 + DEB;   // input change -> stable update edge
  localparam int HOLD = 7;         // counter sits at 5 after this many edges
`else
  localparam int LAT  = 3;
  localparam int HOLD = 2;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'd0;
  logic [WIDTH-1:0] in_port = 4'hF;
  logic [31:0]      readdata;
  logic             irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nios_system_push_buttons #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .EDGE_TYPE      (EDGE_FALL),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    check(tag, readdata, exp);
  endtask

  initial begin
    @(negedge clk);
    step(2);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    step(3);

    // 1. idle after reset
    rd_chk("idle_data", PIO_ADDR_DATA, 32'hF);
    rd_chk("idle_dir", PIO_ADDR_DIR, 32'h0);
    rd_chk("idle_mask", PIO_ADDR_IRQMASK, 32'h0);
    rd_chk("idle_cap", PIO_ADDR_EDGECAP, 32'h0);
    check("idle_irq", {31'd0, irq}, 32'h0);
    wr(PIO_ADDR_DATA, 32'h0);
    wr(PIO_ADDR_DIR, 32'hFFFF_FFFF);
    rd_chk("data_ro", PIO_ADDR_DATA, 32'hF);
    rd_chk("dir_ro", PIO_ADDR_DIR, 32'h0);

    // 3. short pulses on bit 1
`ifdef NIOS_PIO_DEBOUNCE_EN
    for (int r = 0; r < 3; r++) begin
      in_port[1] = 1'b0;
      step(5);
      in_port[1] = 1'b1;
      step(5);
    end
    step(LAT + 2);
    rd_chk("bounce_data", PIO_ADDR_DATA, 32'hF);
    rd_chk("bounce_cap", PIO_ADDR_EDGECAP, 32'h0);
`else
    in_port[1] = 1'b0;
    step(1);
    in_port[1] = 1'b1;
    step(LAT + 2);
    rd_chk("glitch_cap", PIO_ADDR_EDGECAP, 32'h2);
    wr(PIO_ADDR_EDGECAP, 32'h2);
    rd_chk("glitch_clr", PIO_ADDR_EDGECAP, 32'h0);
`endif
    check("pulse_irq_masked", {31'd0, irq}, 32'h0);

    // 2. press bit 0 with its mask enabled
    wr(PIO_ADDR_IRQMASK, 32'h1);
    address    = PIO_ADDR_DATA;
    chipselect = 1'b1;
    in_port[0] = 1'b0;
    step(LAT);
    check("press_data_early", readdata, 32'hF);
    step(1);
    check("press_data", readdata, 32'hE);
    check("press_irq_early", {31'd0, irq}, 32'h0);
    step(1);
    check("press_irq", {31'd0, irq}, 32'h1);
    chipselect = 1'b0;
    rd_chk("press_cap", PIO_ADDR_EDGECAP, 32'h1);

    // 4. clear one bit under mask, then remask
    in_port[1] = 1'b0;
    step(LAT + 3);
    rd_chk("cap_two", PIO_ADDR_EDGECAP, 32'h3);
    wr(PIO_ADDR_IRQMASK, 32'h2);
    step(1);
    check("mask2_irq", {31'd0, irq}, 32'h1);
    wr(PIO_ADDR_EDGECAP, 32'h2);
    check("clr_irq_lag", {31'd0, irq}, 32'h1);
    step(1);
    check("clr_irq", {31'd0, irq}, 32'h0);
    rd_chk("clr_cap", PIO_ADDR_EDGECAP, 32'h1);
    wr(PIO_ADDR_IRQMASK, 32'h1);
    check("remask_irq_lag", {31'd0, irq}, 32'h0);
    step(1);
    check("remask_irq", {31'd0, irq}, 32'h1);
    rd_chk("remask_rd", PIO_ADDR_IRQMASK, 32'h1);

    // 5. bit-2 capture lands on the same edge as a clear of bit 2
    in_port[2] = 1'b0;
    step(LAT);
    wr(PIO_ADDR_EDGECAP, 32'h4);
    rd_chk("set_wins", PIO_ADDR_EDGECAP, 32'h5);
    wr(PIO_ADDR_EDGECAP, 32'h4);
    rd_chk("clr_after", PIO_ADDR_EDGECAP, 32'h1);

    // 6. asynchronous reset mid-operation, then mid-debounce
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    check("async_rst_rd", readdata, 32'h0);
    in_port = 4'hF;
    step(2);
    reset_n = 1'b1;
    step(LAT + 3);
    rd_chk("post_rst_mask", PIO_ADDR_IRQMASK, 32'h0);
    rd_chk("post_rst_cap", PIO_ADDR_EDGECAP, 32'h0);

    in_port[0] = 1'b0;
    step(HOLD);
    reset_n = 1'b0;
    in_port = 4'hF;
    step(2);
    reset_n = 1'b1;
    step(LAT + 3);
    rd_chk("mid_rst_data", PIO_ADDR_DATA, 32'hF);
    rd_chk("mid_rst_cap", PIO_ADDR_EDGECAP, 32'h0);

    // press bit 3: capture register loads on edge LAT+1, visible one read later
    address    = PIO_ADDR_EDGECAP;
    chipselect = 1'b1;
    in_port[3] = 1'b0;
    step(LAT + 1);
    check("b3_cap_early", readdata, 32'h0);
    step(1);
    check("b3_cap", readdata, 32'h8);
    check("b3_irq_masked", {31'd0, irq}, 32'h0);
    chipselect = 1'b0;
    rd_chk("b3_data", PIO_ADDR_DATA, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
